// File: rtl/keypad_scan_4x4.sv
`timescale 1ns/1ps
// keypad_scan_4x4
// Scans a 4x4 matrix keypad and reports one debounced key at a time.
// Columns are driven active-low, one at a time. Rows are sampled once per
// column slot, on the last cycle of the slot (the "tick").
//
// Optional feature: define KEY_REPEAT_EN to re-pulse key_valid every
// REPEAT_TICKS ticks while the accepted key stays held.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   row[3:0]   keypad rows, active low (pulled up externally)
//   col[3:0]   keypad column drive, active low, exactly one bit low
//   press      high while an accepted key is held
//   key_code   row_index*4 + col_index of the last accepted key
//   key_valid  one-cycle strobe on each newly accepted key (and repeats)
module keypad_scan_4x4 #(
  parameter int SCAN_DIV     = 4,
  parameter int STABLE_CNT   = 3,
  parameter int REPEAT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       press,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(STABLE_CNT + 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  // Lowest-numbered low row wins when several rows are pulled down.
  function automatic logic [1:0] first_low_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

  // Active-low one-cold column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] c;
    case (idx)
      2'd0:    c = 4'b1110;
      2'd1:    c = 4'b1101;
      2'd2:    c = 4'b1011;
      2'd3:    c = 4'b0111;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  logic [1:0]       state_r, state_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic [STB_W-1:0] stable_r, stable_s, stable_inc_s;
  logic [1:0]       col_idx_r, col_idx_s;
  logic [1:0]       row_idx_r, row_idx_s;
  logic [3:0]       col_r;
  logic             press_r, press_s;
  logic [3:0]       key_code_r, key_code_s;
  logic             key_valid_r, key_valid_s;
  logic             tick_s;
  logic             rowhit_s;
  logic [1:0]       hit_idx_s;

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
  logic [RPT_W-1:0] rpt_r, rpt_s, rpt_inc_s;
  assign rpt_inc_s = rpt_r + 1'b1;
`else
  logic unused_repeat_s;
  assign unused_repeat_s = (REPEAT_TICKS > 0);
`endif

  // Rows are read straight from the pins; a marginal sample only costs one
  // extra debounce round because acceptance needs STABLE_CNT agreeing ticks.
  assign tick_s       = (div_r == DIV_W'(SCAN_DIV - 1));
  assign rowhit_s     = (row != 4'b1111);
  assign hit_idx_s    = first_low_row(row);
  assign stable_inc_s = stable_r + 1'b1;

  // Next-state logic; apart from the divider, nothing moves off a tick.
  always_comb begin
    state_s     = state_r;
    div_s       = tick_s ? {DIV_W{1'b0}} : div_r + 1'b1;
    stable_s    = stable_r;
    col_idx_s   = col_idx_r;
    row_idx_s   = row_idx_r;
    press_s     = press_r;
    key_code_s  = key_code_r;
    key_valid_s = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_s       = rpt_r;
`endif
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (rowhit_s) begin
            row_idx_s = hit_idx_s;
            if (STABLE_CNT == 1) begin
              state_s     = ST_HOLD;
              stable_s    = {STB_W{1'b0}};
              press_s     = 1'b1;
              key_valid_s = 1'b1;
              key_code_s  = {hit_idx_s, col_idx_r};
`ifdef KEY_REPEAT_EN
              rpt_s       = {RPT_W{1'b0}};
`endif
            end else begin
              state_s  = ST_DEBOUNCE;
              stable_s = STB_W'(1);
            end
          end else begin
            col_idx_s = col_idx_r + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (rowhit_s && (hit_idx_s == row_idx_r)) begin
            if (stable_inc_s == STB_W'(STABLE_CNT)) begin
              state_s     = ST_HOLD;
              stable_s    = {STB_W{1'b0}};
              press_s     = 1'b1;
              key_valid_s = 1'b1;
              key_code_s  = {row_idx_r, col_idx_r};
`ifdef KEY_REPEAT_EN
              rpt_s       = {RPT_W{1'b0}};
`endif
            end else begin
              stable_s = stable_inc_s;
            end
          end else begin
            // Bounce or a different row: give up and move past this column.
            stable_s  = {STB_W{1'b0}};
            state_s   = ST_SCAN;
            col_idx_s = col_idx_r + 2'd1;
          end
        end
        ST_HOLD: begin
`ifdef KEY_REPEAT_EN
          if (!row[row_idx_r]) begin
            key_valid_s = (rpt_inc_s == RPT_W'(REPEAT_TICKS));
            rpt_s       = key_valid_s ? {RPT_W{1'b0}} : rpt_inc_s;
          end else begin
            rpt_s = rpt_r;
          end
`endif
          // Any low row in the frozen column (same key or another key in
          // that column) keeps the hold alive.
          if (rowhit_s) begin
            stable_s = {STB_W{1'b0}};
          end else if (stable_inc_s == STB_W'(STABLE_CNT)) begin
            state_s   = ST_SCAN;
            stable_s  = {STB_W{1'b0}};
            press_s   = 1'b0;
            col_idx_s = 2'd0;
            div_s     = {DIV_W{1'b0}};
`ifdef KEY_REPEAT_EN
            rpt_s     = {RPT_W{1'b0}};
`endif
          end else begin
            stable_s = stable_inc_s;
          end
        end
        default: begin
          state_s   = ST_SCAN;
          stable_s  = {STB_W{1'b0}};
          col_idx_s = 2'd0;
          press_s   = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_SCAN;
      div_r       <= {DIV_W{1'b0}};
      stable_r    <= {STB_W{1'b0}};
      col_idx_r   <= 2'd0;
      row_idx_r   <= 2'd0;
      col_r       <= 4'b1110;
      press_r     <= 1'b0;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_r       <= {RPT_W{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      stable_r    <= stable_s;
      col_idx_r   <= col_idx_s;
      row_idx_r   <= row_idx_s;
      col_r       <= col_drive(col_idx_s);
      press_r     <= press_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
`ifdef KEY_REPEAT_EN
      rpt_r       <= rpt_s;
`endif
    end
  end

  assign col       = col_r;
  assign press     = press_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
`timescale 1ns/1ps
// Bench for keypad_scan_4x4: a keypad contact matrix drives the rows from
// the DUT's column drive, and a tick-level reference model predicts the
// outputs from the scanning/debounce rules.
module tb_keypad_scan_4x4;

  localparam int SCAN_DIV     = 4;
  localparam int STABLE_CNT   = 3;
  localparam int REPEAT_TICKS = 2;

  localparam int M_IDLE    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HOLD    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        press;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] keys = 16'd0;   // bit r*4+c: key at row r, column c closed

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  int         m_phase, m_mode, m_colidx, m_cand, m_rep;
  int         hist[$];
  logic       m_press, m_valid;
  logic [3:0] m_code;

  keypad_scan_4x4 #(
    .SCAN_DIV(SCAN_DIV), .STABLE_CNT(STABLE_CNT), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .press(press), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key shorts its row to its column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] act, input logic [3:0] mdl,
                     input logic [3:0] exp);
    chk(name, act, exp);
    chk({"model_", name}, mdl, exp);
  endtask

  function automatic logic [3:0] m_col();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m_colidx);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_mode = M_IDLE; m_colidx = 0; m_cand = 0; m_rep = 0;
    hist.delete();
    m_press = 1'b0; m_valid = 1'b0; m_code = 4'd0;
  endtask

  task automatic accept();
    m_mode  = M_HOLD;
    hist.delete();
    m_press = 1'b1;
    m_valid = 1'b1;
    m_code  = 4'(m_cand * 4 + m_colidx);
    m_rep   = 0;
  endtask

  // Advance the model over one rising edge with the current keys.
  task automatic model_step();
    int  smp;
    bit  tick;
    bit  all_high;
    if (!rst) begin
      model_reset();
      return;
    end
    tick    = (m_phase == SCAN_DIV - 1);
    m_valid = 1'b0;
    m_phase = (m_phase + 1) % SCAN_DIV;
    if (!tick) return;
    smp = -1;
    for (int r = 3; r >= 0; r--) if (keys[r*4 + m_colidx]) smp = r;
    if (m_mode == M_IDLE) begin
      if (smp >= 0) begin
        m_cand = smp;
        hist.delete();
        hist.push_back(smp);
        if (hist.size() >= STABLE_CNT) accept();
        else m_mode = M_CONFIRM;
      end else begin
        m_colidx = (m_colidx + 1) % 4;
      end
    end else if (m_mode == M_CONFIRM) begin
      if (smp == m_cand) begin
        hist.push_back(smp);
        if (hist.size() >= STABLE_CNT) accept();
      end else begin
        hist.delete();
        m_mode   = M_IDLE;
        m_colidx = (m_colidx + 1) % 4;
      end
    end else begin
`ifdef KEY_REPEAT_EN
      if (keys[m_cand*4 + m_colidx]) begin
        m_rep++;
        if (m_rep == REPEAT_TICKS) begin
          m_valid = 1'b1;
          m_rep   = 0;
        end
      end
`endif
      hist.push_back(smp);
      if (hist.size() > STABLE_CNT) void'(hist.pop_front());
      all_high = (hist.size() == STABLE_CNT);
      foreach (hist[i]) if (hist[i] != -1) all_high = 0;
      if (all_high) begin
        m_press  = 1'b0;
        m_mode   = M_IDLE;
        m_colidx = 0;
        m_phase  = 0;
        m_rep    = 0;
        hist.delete();
      end
    end
  endtask

  // Compare DUT to the model for the current cycle, then advance one clock.
  task automatic tick_cycle();
    chk("col", col, m_col());
    chk("press", {3'd0, press}, {3'd0, m_press});
    chk("key_code", key_code, m_code);
    chk("key_valid", {3'd0, key_valid}, {3'd0, m_valid});
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick_cycle();
  endtask

  // Asynchronous reset: outputs must drop without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_press", {3'd0, press}, 4'd0);
    chk("rst_code", key_code, 4'd0);
    chk("rst_valid", {3'd0, key_valid}, 4'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    logic [3:0] col_exp[5];
    int         col_cyc[5];
    int         r;
    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    col_cyc = '{0, 4, 8, 12, 16};
    model_reset();
    @(negedge clk);

    // 1. idle scan
    do_reset();
    keys = 16'd0;
    for (int i = 0; i < 5; i++) begin
      goto(col_cyc[i]);
      lit("idle_col", col, m_col(), col_exp[i]);
    end
    lit("idle_press", {3'd0, press}, {3'd0, m_press}, 4'd0);

    // 2. clean press of row1/col2, then 4. release at cycle 30
    do_reset();
    keys = 16'(1) << 6;
    goto(19);
    lit("t2_press19", {3'd0, press}, {3'd0, m_press}, 4'd0);
    goto(20);
    lit("t2_press20", {3'd0, press}, {3'd0, m_press}, 4'd1);
    lit("t2_valid20", {3'd0, key_valid}, {3'd0, m_valid}, 4'd1);
    lit("t2_code20", key_code, m_code, 4'd6);
    goto(21);
    lit("t2_valid21", {3'd0, key_valid}, {3'd0, m_valid}, 4'd0);
    goto(28);
`ifdef KEY_REPEAT_EN
    lit("t6_valid28", {3'd0, key_valid}, {3'd0, m_valid}, 4'd1);
`else
    lit("t6_valid28", {3'd0, key_valid}, {3'd0, m_valid}, 4'd0);
`endif
    goto(30);
    keys = 16'd0;
    goto(39);
    lit("t4_press39", {3'd0, press}, {3'd0, m_press}, 4'd1);
    goto(40);
    lit("t4_press40", {3'd0, press}, {3'd0, m_press}, 4'd0);
    lit("t4_col40", col, m_col(), 4'b1110);
    lit("t4_code40", key_code, m_code, 4'd6);
    goto(48);

    // 3. bounce rejection, then clean re-press
    do_reset();
    keys = 16'(1) << 6;
    goto(15);
    keys = 16'd0;
    goto(16);
    lit("t3_col16", col, m_col(), 4'b0111);
    lit("t3_press16", {3'd0, press}, {3'd0, m_press}, 4'd0);
    keys = 16'(1) << 6;
    goto(40);
    lit("t3_press40", {3'd0, press}, {3'd0, m_press}, 4'd1);
    lit("t3_valid40", {3'd0, key_valid}, {3'd0, m_valid}, 4'd1);
    lit("t3_code40", key_code, m_code, 4'd6);

    // 5. priority, ignored second key, reset mid-hold
    do_reset();
    keys = (16'(1) << 1) | (16'(1) << 13);
    goto(16);
    lit("t5_code16", key_code, m_code, 4'd1);
    lit("t5_valid16", {3'd0, key_valid}, {3'd0, m_valid}, 4'd1);
    goto(20);
    keys = keys | (16'(1) << 11);
    goto(40);
    lit("t5_press40", {3'd0, press}, {3'd0, m_press}, 4'd1);
    lit("t5_code40", key_code, m_code, 4'd1);
    do_reset();
    goto(16);
    lit("t5_redetect16", {3'd0, key_valid}, {3'd0, m_valid}, 4'd1);
    goto(24);

    // randomized keypad activity with occasional resets
    keys = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2)       keys = keys ^ (16'(1) << $urandom_range(0, 15));
      else if (r < 4)  keys = 16'd0;
      else if (r < 6)  keys = 16'(1) << $urandom_range(0, 15);
      else if (r == 6 && $urandom_range(0, 9) == 0) do_reset();
      tick_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
